// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the four-digit BCD display counter controller.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0]  BCD_NINE         = 4'h9;
  localparam int          NUM_DIGITS       = 4;
  localparam logic [15:0] DEFAULT_TERMINAL = 16'h9675;

  // Decimal carry ripple: digit 0 always advances, digit i advances only when
  // every lower digit currently reads nine. A non-BCD digit is never nine, so
  // it stops the ripple at that position.
  function automatic logic [NUM_DIGITS-1:0] carry_mask(input logic [4*NUM_DIGITS-1:0] dig);
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_nine;
    mask     = '0;
    mask[0]  = 1'b1;
    all_nine = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      all_nine = all_nine & (dig[4*(i-1) +: 4] == BCD_NINE);
      mask[i]  = all_nine;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles (PRESCALE 2..65535).
// Latency: tick is combinational from the held count and en, high in the last count cycle.
// Backpressure: dropping en freezes the count in place; clr forces it back to zero.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear wins, disabled holds, enabled counts and wraps with a tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencer for four external BCD digit counters: tick generation, carry gating, terminal detect.
// Latency: dig_inc/dig_clr are registered, one cycle after tick; digits settle one cycle later.
// Backpressure: none; start/pause/clear are single-cycle pulses, priority clear > pause > start.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter logic [15:0] TERMINAL = DEFAULT_TERMINAL,
  parameter bit          WRAP     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [15:0]           dig_q,
  output logic [NUM_DIGITS-1:0] dig_inc,
  output logic                  dig_clr,
  output logic                  running,
  output logic                  done,
  output logic                  tick
);

  state_e                state_q;
  state_e                state_d;
  logic [NUM_DIGITS-1:0] dig_inc_q;
  logic [NUM_DIGITS-1:0] dig_inc_d;
  logic                  dig_clr_q;
  logic                  dig_clr_d;

  logic                  presc_en;
  logic                  presc_clr;
  logic                  presc_tick;
  logic                  at_term;
  logic [NUM_DIGITS-1:0] inc_mask;

  // The prescaler only advances while staying in RUN, so a pause or clear
  // freezes it in the same cycle and cannot produce a tick that gets dropped.
  assign presc_en  = (state_q == RUN) && !clear && !pause;
  assign presc_clr = clear;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (presc_tick)
  );

  assign at_term  = (dig_q == TERMINAL);
  assign inc_mask = carry_mask(dig_q);

  // Next state and next digit strobes; clear overrides everything else.
  always_comb begin
    state_d   = state_q;
    dig_inc_d = '0;
    dig_clr_d = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      dig_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (presc_tick) begin
            if (at_term) begin
              if (WRAP) dig_clr_d = 1'b1;
              else      state_d   = DONE;
            end else begin
              dig_inc_d = inc_mask;
            end
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and strobe registers; reset leaves one dig_clr pulse to zero the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dig_inc_q <= '0;
      dig_clr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dig_inc_q <= dig_inc_d;
      dig_clr_q <= dig_clr_d;
    end
  end

  assign dig_inc = dig_inc_q;
  assign dig_clr = dig_clr_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign tick    = presc_tick;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (stop-at-terminal and wrapping), each with digit models.
// Latency: strobes are checked one cycle after each observed tick through an action queue.
// Backpressure: n/a.
module tb_bcd_count_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start0 = 1'b0, pause0 = 1'b0, clear0 = 1'b0;
  logic        start1 = 1'b0, pause1 = 1'b0, clear1 = 1'b0;
  logic [15:0] d0 = 16'h4321;
  logic [15:0] d1 = 16'h8765;
  logic        ld0 = 1'b0, ld1 = 1'b0;
  logic [15:0] ldv0 = 16'h0, ldv1 = 16'h0;
  logic [3:0]  dig_inc0, dig_inc1;
  logic        dig_clr0, dig_clr1, running0, running1, done0, done1, tick0, tick1;

  bcd_count_ctrl #(.PRESCALE(4), .TERMINAL(16'h9675), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pause(pause0), .clear(clear0), .dig_q(d0),
    .dig_inc(dig_inc0), .dig_clr(dig_clr0), .running(running0), .done(done0), .tick(tick0));

  bcd_count_ctrl #(.PRESCALE(4), .TERMINAL(16'h9675), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .pause(pause1), .clear(clear1), .dig_q(d1),
    .dig_inc(dig_inc1), .dig_clr(dig_clr1), .running(running1), .done(done1), .tick(tick1));

  // Digit counter models: load (bench preload) > clear > per-digit increment rolling 9 to 0.
  always @(posedge clk) begin
    if (ld0) d0 <= ldv0;
    else if (dig_clr0) d0 <= 16'h0;
    else for (int i = 0; i < 4; i++)
      if (dig_inc0[i]) d0[4*i +: 4] <= (d0[4*i +: 4] == 4'h9) ? 4'h0 : d0[4*i +: 4] + 4'h1;
  end

  always @(posedge clk) begin
    if (ld1) d1 <= ldv1;
    else if (dig_clr1) d1 <= 16'h0;
    else for (int i = 0; i < 4; i++)
      if (dig_inc1[i]) d1[4*i +: 4] <= (d1[4*i +: 4] == 4'h9) ? 4'h0 : d1[4*i +: 4] + 4'h1;
  end

  typedef struct packed {
    logic [3:0] inc;
    logic       clr;
  } act_t;

  typedef struct packed {
    logic [15:0] pre;
    logic [3:0]  inc;
    logic [15:0] post;
  } vec_t;

  act_t q0[$];
  act_t q1[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected strobes for a tick seen with digits d.
  function automatic act_t expect_act(input logic [15:0] d, input bit wrap);
    act_t a;
    a.inc = 4'b0000;
    a.clr = 1'b0;
    if (d == 16'h9675) begin
      a.clr = wrap;
    end else begin
      a.inc[0] = 1'b1;
      if (d[3:0] == 4'h9) begin
        a.inc[1] = 1'b1;
        if (d[7:4] == 4'h9) begin
          a.inc[2] = 1'b1;
          if (d[11:8] == 4'h9) a.inc[3] = 1'b1;
        end
      end
    end
    return a;
  endfunction

  // One clock step: sample on the falling edge, settle last cycle's expectations, queue new ones.
  task automatic step();
    act_t e;
    @(negedge clk);
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("sb0_action", {27'd0, dig_clr0, dig_inc0}, {27'd0, e.clr, e.inc});
    end else begin
      chk("sb0_no_inc", {28'd0, dig_inc0}, 32'd0);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("sb1_action", {27'd0, dig_clr1, dig_inc1}, {27'd0, e.clr, e.inc});
    end else begin
      chk("sb1_no_inc", {28'd0, dig_inc1}, 32'd0);
    end
    if (tick0) q0.push_back(expect_act(d0, 1'b0));
    if (tick1) q1.push_back(expect_act(d1, 1'b1));
  endtask

  task automatic wait_tick(input int which, output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if ((which == 0 && tick0) || (which == 1 && tick1)) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      fails++;
      $display("FAIL tick_timeout dut=%0d actual=none required=tick within 64 cycles", which);
    end
  endtask

  initial begin
    vec_t        vecs[8];
    int          n;
    logic        ok;
    logic [15:0] snap;
    int          clr_seen;
    int          inc_seen;

    vecs[0] = '{pre: 16'h0999, inc: 4'b1111, post: 16'h1000};
    vecs[1] = '{pre: 16'h0009, inc: 4'b0011, post: 16'h0010};
    vecs[2] = '{pre: 16'h0099, inc: 4'b0111, post: 16'h0100};
    vecs[3] = '{pre: 16'h1239, inc: 4'b0011, post: 16'h1240};
    vecs[4] = '{pre: 16'h9999, inc: 4'b1111, post: 16'h0000};
    vecs[5] = '{pre: 16'h00A9, inc: 4'b0011, post: 16'h00B0};
    vecs[6] = '{pre: 16'h0A99, inc: 4'b0111, post: 16'h0B00};
    vecs[7] = '{pre: 16'h9674, inc: 4'b0001, post: 16'h9675};

    // Reset state, then release: one dig_clr pulse zeroes the digits.
    step();
    step();
    chk("rst_dig_clr", {31'd0, dig_clr0}, 32'd1);
    chk("rst_dig_inc", {28'd0, dig_inc0}, 32'd0);
    chk("rst_running", {31'd0, running0}, 32'd0);
    chk("rst_done",    {31'd0, done0},    32'd0);
    chk("rst_tick",    {31'd0, tick0},    32'd0);
    rst = 1'b0;
    step();
    chk("rel_dig_clr", {31'd0, dig_clr0}, 32'd0);
    chk("rel_digits0", {16'd0, d0}, 32'h0000);
    chk("rel_digits1", {16'd0, d1}, 32'h0000);

    // Start: first strobe 4 + 1 cycles later, then ten ticks reach 0010.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("start_running", {31'd0, running0}, 32'd1);
    n = 1;
    while (dig_inc0 == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk("first_inc_latency", n, 5);
    chk("first_inc_value", {28'd0, dig_inc0}, 32'h1);
    for (int k = 2; k <= 9; k++) begin
      if (k == 5) begin
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_tick(0, n);
        chk("start_in_run_no_restart", n, 2);
      end else begin
        wait_tick(0, n);
        if (k == 3) chk("tick_interval", n, 4);
      end
    end
    wait_tick(0, n);
    chk("tick10_digits", {16'd0, d0}, 32'h0009);
    step();
    chk("tick10_inc", {28'd0, dig_inc0}, 32'h3);
    step();
    chk("tick10_after", {16'd0, d0}, 32'h0010);

    // Table: preload digits between ticks, check carry strobes and settled digits.
    for (int v = 0; v < 8; v++) begin
      wait_tick(0, n);
      step();
      step();
      ld0  = 1'b1;
      ldv0 = vecs[v].pre;
      step();
      ld0 = 1'b0;
      wait_tick(0, n);
      chk($sformatf("vec%0d_pre", v), {16'd0, d0}, {16'd0, vecs[v].pre});
      step();
      chk($sformatf("vec%0d_inc", v), {28'd0, dig_inc0}, {28'd0, vecs[v].inc});
      step();
      chk($sformatf("vec%0d_post", v), {16'd0, d0}, {16'd0, vecs[v].post});
    end

    // Terminal with WRAP=0: no strobe, DONE next cycle, digits hold.
    wait_tick(0, n);
    step();
    chk("term_done",    {31'd0, done0},    32'd1);
    chk("term_running", {31'd0, running0}, 32'd0);
    chk("term_no_inc",  {28'd0, dig_inc0}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (d0 != 16'h9675 || tick0 || !done0) ok = 1'b0;
    end
    chk("done_hold_100", {31'd0, ok}, 32'd1);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    chk("done_ignores_start", {31'd0, done0}, 32'd1);

    // Reset while in DONE.
    rst = 1'b1;
    step();
    chk("rst_in_done_done", {31'd0, done0}, 32'd0);
    chk("rst_in_done_clr",  {31'd0, dig_clr0}, 32'd1);
    rst = 1'b0;
    step();
    chk("rst_in_done_digits", {16'd0, d0}, 32'h0000);

    // Pause with the prescaler at 2, hold 20 cycles, resume: tick 2 cycles after start.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    wait_tick(0, n);
    step();
    step();
    step();
    pause0 = 1'b1;
    step();
    pause0 = 1'b0;
    chk("pause_running", {31'd0, running0}, 32'd0);
    snap = d0;
    ok   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick0 || d0 != snap) ok = 1'b0;
    end
    chk("pause_frozen", {31'd0, ok}, 32'd1);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 1;
    while (!tick0 && n < 20) begin
      step();
      n++;
    end
    chk("resume_tick_delay", n, 2);

    // clear + pause together mid-RUN: IDLE, single dig_clr, no further strobes.
    step();
    step();
    step();
    clear0 = 1'b1;
    pause0 = 1'b1;
    step();
    clear0 = 1'b0;
    pause0 = 1'b0;
    chk("clrpause_dig_clr", {31'd0, dig_clr0}, 32'd1);
    chk("clrpause_running", {31'd0, running0}, 32'd0);
    clr_seen = 0;
    inc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dig_clr0) clr_seen++;
      if (dig_inc0 != 4'd0) inc_seen++;
    end
    chk("clrpause_extra_clr", clr_seen, 0);
    chk("clrpause_inc", inc_seen, 0);
    chk("clrpause_digits", {16'd0, d0}, 32'h0000);

    // clear in IDLE reissues the clear strobe.
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    chk("idle_clear_pulse", {31'd0, dig_clr0}, 32'd1);
    step();
    chk("idle_clear_once", {31'd0, dig_clr0}, 32'd0);

    // WRAP=1 instance: terminal tick clears digits and counting continues.
    ld1  = 1'b1;
    ldv1 = 16'h9675;
    step();
    ld1    = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_tick(1, n);
    chk("wrap_first_tick", n, 3);
    chk("wrap_at_term", {16'd0, d1}, 32'h9675);
    step();
    chk("wrap_clr", {31'd0, dig_clr1}, 32'd1);
    chk("wrap_no_inc", {28'd0, dig_inc1}, 32'd0);
    step();
    chk("wrap_digits_zero", {16'd0, d1}, 32'h0000);
    chk("wrap_running", {31'd0, running1}, 32'd1);
    chk("wrap_done_low", {31'd0, done1}, 32'd0);
    wait_tick(1, n);
    chk("wrap_next_tick", n, 2);
    step();
    chk("wrap_inc_after", {28'd0, dig_inc1}, 32'h1);
    step();
    chk("wrap_digits_one", {16'd0, d1}, 32'h0001);
    chk("wrap_done_still_low", {31'd0, done1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
